// File: rtl/player_pkg.sv
// Shared constants, state encoding and tile-index helper for the player controller.
package player_pkg;

   // USB HID keycodes for the movement keys
   localparam logic [7:0] KEY_A = 8'h04;
   localparam logic [7:0] KEY_D = 8'h07;
   localparam logic [7:0] KEY_W = 8'h1A;
   localparam logic [7:0] KEY_S = 8'h16;

   // Wall bit positions inside each 4-bit corner bound word
   localparam int unsigned BND_LEFT  = 0;
   localparam int unsigned BND_RIGHT = 1;
   localparam int unsigned BND_UP    = 2;
   localparam int unsigned BND_DOWN  = 3;

   localparam int unsigned POS_W  = 10;
   localparam int unsigned SPOS_W = 11;
   localparam int unsigned STEP_W = 3;

   typedef enum logic [1:0] {
      PLAY  = 2'd0,
      DYING = 2'd1
   } state_t;

   // Linear tile index of the tile that contains pixel (x, y)
   function automatic logic [31:0] tile_index(input logic [POS_W-1:0] x,
                                              input logic [POS_W-1:0] y,
                                              input int unsigned      shift,
                                              input int unsigned      cols);
      logic [31:0] row;
      logic [31:0] col;
      row = 32'(y) >> shift;
      col = 32'(x) >> shift;
      return row * cols + col;
   endfunction

endpackage

// File: rtl/bcd_counter.sv
// Multi-digit BCD up-counter with synchronous clear; saturates at all nines.
module bcd_counter #(
   parameter int unsigned DIGITS = 3
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  clr,
   input  logic                  inc,
   output logic [4*DIGITS-1:0]   count
);

   logic [4*DIGITS-1:0] count_q;
   logic [4*DIGITS-1:0] count_d;
   logic [4*DIGITS-1:0] count_inc;
   logic                all_nines;
   logic                carry;

   // Ripple the +1 through every digit and detect the saturation value
   always_comb begin
      count_inc = count_q;
      all_nines = 1'b1;
      carry     = 1'b1;
      for (int i = 0; i < int'(DIGITS); i++) begin
         if (count_q[4*i +: 4] != 4'd9) all_nines = 1'b0;
         if (carry) begin
            if (count_q[4*i +: 4] == 4'd9) begin
               count_inc[4*i +: 4] = 4'd0;
            end else begin
               count_inc[4*i +: 4] = count_q[4*i +: 4] + 4'd1;
               carry               = 1'b0;
            end
         end
      end
   end

   // Clear wins over increment; a saturated counter holds
   always_comb begin
      count_d = count_q;
      if (clr)                   count_d = '0;
      else if (inc && !all_nines) count_d = count_inc;
   end

   // Counter register
   always_ff @(posedge clk) begin
      if (rst) count_q <= '0;
      else     count_q <= count_d;
   end

   assign count = count_q;

endmodule

// File: rtl/player_ctrl_gen.sv
// Player sprite controller: keycode decode, per-axis tile collision, screen clamp,
// death/respawn FSM and BCD death counter.
// Optional build macro PLAYER_ACCEL_EN: per-axis speed ramps from 1 up to SPEED.
module player_ctrl_gen
   import player_pkg::*;
#(
   parameter int unsigned SPEED          = 2,
   parameter int unsigned PLAYER_SIZE    = 20,
   parameter int unsigned TILE_SHIFT     = 5,
   parameter int unsigned GRID_COLS      = 20,
   parameter int unsigned IDX_W          = 12,
   parameter int unsigned X_MAX          = 639,
   parameter int unsigned Y_MAX          = 479,
   parameter int unsigned RESPAWN_FRAMES = 30,
   parameter int unsigned DEATH_DIGITS   = 3,
   parameter int unsigned KEY_SLOTS      = 4
) (
   input  logic                      frame_clk,
   input  logic                      Reset,
   input  logic                      dead,
   input  logic                      initialize_level,
   input  logic                      new_level,
   input  logic [8*KEY_SLOTS-1:0]    keycode,
   input  logic [9:0]                spawn_x,
   input  logic [9:0]                spawn_y,
   input  logic [3:0]                tl_bound,
   input  logic [3:0]                tr_bound,
   input  logic [3:0]                bl_bound,
   input  logic [3:0]                br_bound,
   output logic [9:0]                PlayerX,
   output logic [9:0]                PlayerY,
   output logic [9:0]                PlayerS,
   output logic [IDX_W-1:0]          tl_index,
   output logic [IDX_W-1:0]          tr_index,
   output logic [IDX_W-1:0]          bl_index,
   output logic [IDX_W-1:0]          br_index,
   output logic                      player_visible,
   output logic [1:0]                state_o,
   output logic [4*DEATH_DIGITS-1:0] death_bcd
);

   localparam int unsigned TILE  = 1 << TILE_SHIFT;
   localparam int unsigned CNT_W = (RESPAWN_FRAMES > 1) ? $clog2(RESPAWN_FRAMES) : 1;
   localparam logic signed [SPOS_W-1:0] HALF_S  = SPOS_W'(PLAYER_SIZE / 2);
   localparam logic signed [SPOS_W-1:0] XMAX_S  = SPOS_W'(X_MAX);
   localparam logic signed [SPOS_W-1:0] YMAX_S  = SPOS_W'(Y_MAX);

   state_t             state_q, state_d;
   logic [POS_W-1:0]   x_q, x_d, y_q, y_d;
   logic               vis_q, vis_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               death_inc, death_clr;
   logic               lvl_load;

   logic               key_a, key_d, key_w, key_s;
   logic               mv_l, mv_r, mv_u, mv_dn;
   logic [STEP_W-1:0]  step_x, step_y;
   logic signed [SPOS_W-1:0] xs, ys, l_e, r_e, t_e, b_e;
   logic [TILE_SHIFT-1:0]    l_off, r_off, t_off, b_off;
   logic               blk_l, blk_r, blk_u, blk_dn;
   logic signed [SPOS_W-1:0] nx, ny;
   logic               unused_ok;

`ifdef PLAYER_ACCEL_EN
   logic [STEP_W-1:0]  spd_x_q, spd_x_d, spd_y_q, spd_y_d;
   logic               neg_x_q, neg_x_d, neg_y_q, neg_y_d;
   logic [STEP_W-1:0]  spd_x_nx, spd_y_nx;
`endif

   assign lvl_load = initialize_level | new_level;

   // Collect the movement keys from every slot, independent of slot order
   always_comb begin
      key_a = 1'b0;
      key_d = 1'b0;
      key_w = 1'b0;
      key_s = 1'b0;
      for (int k = 0; k < int'(KEY_SLOTS); k++) begin
         if (keycode[8*k +: 8] == KEY_A) key_a = 1'b1;
         if (keycode[8*k +: 8] == KEY_D) key_d = 1'b1;
         if (keycode[8*k +: 8] == KEY_W) key_w = 1'b1;
         if (keycode[8*k +: 8] == KEY_S) key_s = 1'b1;
      end
      mv_l  = key_a & ~key_d;
      mv_r  = key_d & ~key_a;
      mv_u  = key_w & ~key_s;
      mv_dn = key_s & ~key_w;
   end

   // Sprite edges and corner tile indices from the registered centre
   always_comb begin
      xs  = signed'({1'b0, x_q});
      ys  = signed'({1'b0, y_q});
      l_e = xs - HALF_S;
      r_e = xs + HALF_S;
      t_e = ys - HALF_S;
      b_e = ys + HALF_S;
      l_off = l_e[TILE_SHIFT-1:0];
      r_off = r_e[TILE_SHIFT-1:0];
      t_off = t_e[TILE_SHIFT-1:0];
      b_off = b_e[TILE_SHIFT-1:0];
      tl_index = IDX_W'(tile_index(POS_W'(l_e), POS_W'(t_e), TILE_SHIFT, GRID_COLS));
      tr_index = IDX_W'(tile_index(POS_W'(r_e), POS_W'(t_e), TILE_SHIFT, GRID_COLS));
      bl_index = IDX_W'(tile_index(POS_W'(l_e), POS_W'(b_e), TILE_SHIFT, GRID_COLS));
      br_index = IDX_W'(tile_index(POS_W'(r_e), POS_W'(b_e), TILE_SHIFT, GRID_COLS));
   end

`ifdef PLAYER_ACCEL_EN
   // Step ramps while the same direction stays held, restarting at 1 otherwise
   always_comb begin
      step_x = STEP_W'(1);
      step_y = STEP_W'(1);
      if (spd_x_q != '0 && neg_x_q == mv_l)
         step_x = (spd_x_q >= STEP_W'(SPEED)) ? STEP_W'(SPEED) : spd_x_q + STEP_W'(1);
      if (spd_y_q != '0 && neg_y_q == mv_u)
         step_y = (spd_y_q >= STEP_W'(SPEED)) ? STEP_W'(SPEED) : spd_y_q + STEP_W'(1);
   end
`else
   // Constant step
   always_comb begin
      step_x = STEP_W'(SPEED);
      step_y = STEP_W'(SPEED);
   end
`endif

   // Per-axis wall test, move and screen clamp
   always_comb begin
      blk_l  = mv_l  && (32'(l_off) < 32'(step_x)) &&
               (tl_bound[BND_LEFT] || bl_bound[BND_LEFT]);
      blk_r  = mv_r  && (32'(r_off) >= 32'(TILE) - 32'(step_x)) &&
               (tr_bound[BND_RIGHT] || br_bound[BND_RIGHT]);
      blk_u  = mv_u  && (32'(t_off) < 32'(step_y)) &&
               (tl_bound[BND_UP] || tr_bound[BND_UP]);
      blk_dn = mv_dn && (32'(b_off) >= 32'(TILE) - 32'(step_y)) &&
               (bl_bound[BND_DOWN] || br_bound[BND_DOWN]);

      nx = xs;
      if (mv_l && !blk_l)      nx = xs - signed'(SPOS_W'(step_x));
      else if (mv_r && !blk_r) nx = xs + signed'(SPOS_W'(step_x));
      if (nx - HALF_S < 0)             nx = HALF_S;
      else if (nx + HALF_S > XMAX_S)   nx = XMAX_S - HALF_S;

      ny = ys;
      if (mv_u && !blk_u)        ny = ys - signed'(SPOS_W'(step_y));
      else if (mv_dn && !blk_dn) ny = ys + signed'(SPOS_W'(step_y));
      if (ny - HALF_S < 0)             ny = HALF_S;
      else if (ny + HALF_S > YMAX_S)   ny = YMAX_S - HALF_S;
   end

`ifdef PLAYER_ACCEL_EN
   // Speed carried into the next frame; zero when idle or blocked
   always_comb begin
      spd_x_nx = ((mv_l && !blk_l) || (mv_r && !blk_r)) ? step_x : '0;
      spd_y_nx = ((mv_u && !blk_u) || (mv_dn && !blk_dn)) ? step_y : '0;
   end
`endif

   // FSM state register
   always_ff @(posedge frame_clk) begin
      if (Reset) state_q <= PLAY;
      else       state_q <= state_d;
   end

   // FSM next state: level load overrides, then death, then freeze expiry
   always_comb begin
      state_d = state_q;
      if (lvl_load) begin
         state_d = PLAY;
      end else begin
         case (state_q)
            PLAY:    if (dead) state_d = DYING;
            DYING:   if (cnt_q == '0) state_d = PLAY;
            default: state_d = PLAY;
         endcase
      end
   end

   // FSM outputs: next position, visibility, freeze counter, death counter strobes
   always_comb begin
      x_d       = x_q;
      y_d       = y_q;
      vis_d     = vis_q;
      cnt_d     = cnt_q;
      death_inc = 1'b0;
      death_clr = 1'b0;
`ifdef PLAYER_ACCEL_EN
      spd_x_d = '0;
      spd_y_d = '0;
      neg_x_d = neg_x_q;
      neg_y_d = neg_y_q;
`endif
      if (lvl_load) begin
         x_d       = spawn_x;
         y_d       = spawn_y;
         vis_d     = 1'b1;
         cnt_d     = '0;
         death_clr = 1'b1;
      end else begin
         case (state_q)
            PLAY: begin
               if (dead) begin
                  x_d       = spawn_x;
                  y_d       = spawn_y;
                  vis_d     = 1'b0;
                  cnt_d     = CNT_W'(RESPAWN_FRAMES - 1);
                  death_inc = 1'b1;
               end else begin
                  x_d = POS_W'(nx);
                  y_d = POS_W'(ny);
`ifdef PLAYER_ACCEL_EN
                  spd_x_d = spd_x_nx;
                  spd_y_d = spd_y_nx;
                  neg_x_d = mv_l;
                  neg_y_d = mv_u;
`endif
               end
            end
            DYING: begin
               if (cnt_q == '0) vis_d = 1'b1;
               else             cnt_d = cnt_q - CNT_W'(1);
            end
            default: vis_d = 1'b1;
         endcase
      end
   end

   // Datapath registers
   always_ff @(posedge frame_clk) begin
      if (Reset) begin
         x_q   <= spawn_x;
         y_q   <= spawn_y;
         vis_q <= 1'b1;
         cnt_q <= '0;
      end else begin
         x_q   <= x_d;
         y_q   <= y_d;
         vis_q <= vis_d;
         cnt_q <= cnt_d;
      end
   end

`ifdef PLAYER_ACCEL_EN
   // Velocity registers
   always_ff @(posedge frame_clk) begin
      if (Reset) begin
         spd_x_q <= '0;
         spd_y_q <= '0;
         neg_x_q <= 1'b0;
         neg_y_q <= 1'b0;
      end else begin
         spd_x_q <= spd_x_d;
         spd_y_q <= spd_y_d;
         neg_x_q <= neg_x_d;
         neg_y_q <= neg_y_d;
      end
   end
`endif

   bcd_counter #(
      .DIGITS (DEATH_DIGITS)
   ) u_bcd (
      .clk   (frame_clk),
      .rst   (Reset),
      .clr   (death_clr),
      .inc   (death_inc),
      .count (death_bcd)
   );

   assign PlayerX        = x_q;
   assign PlayerY        = y_q;
   assign PlayerS        = 10'(PLAYER_SIZE);
   assign player_visible = vis_q;
   assign state_o        = state_q;

   // Bound bits that face away from a corner never gate motion
   assign unused_ok = ^{tl_bound[BND_RIGHT], tl_bound[BND_DOWN],
                        tr_bound[BND_LEFT],  tr_bound[BND_DOWN],
                        bl_bound[BND_RIGHT], bl_bound[BND_UP],
                        br_bound[BND_LEFT],  br_bound[BND_UP],
                        l_e[SPOS_W-1], r_e[SPOS_W-1], t_e[SPOS_W-1], b_e[SPOS_W-1]};

endmodule

// File: tb/tb_player_ctrl_gen.sv
// Self-checking bench for player_ctrl_gen: reset, slot-independent movement,
// wall blocking, screen clamp, death/respawn, BCD saturation and level clear.
module tb_player_ctrl_gen;
   import player_pkg::*;

   logic        frame_clk = 1'b0;
   logic        Reset;
   logic        dead;
   logic        initialize_level;
   logic        new_level;
   logic [31:0] keycode;
   logic [9:0]  spawn_x, spawn_y;
   logic [3:0]  tl_bound, tr_bound, bl_bound, br_bound;
   logic [9:0]  PlayerX, PlayerY, PlayerS;
   logic [11:0] tl_index, tr_index, bl_index, br_index;
   logic        player_visible;
   logic [1:0]  state_o;
   logic [11:0] death_bcd;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      int x;
      int y;
      int st;
      int vis;
      int bcd;
   } exp_t;

   exp_t sb[$];

   player_ctrl_gen dut (
      .frame_clk        (frame_clk),
      .Reset            (Reset),
      .dead             (dead),
      .initialize_level (initialize_level),
      .new_level        (new_level),
      .keycode          (keycode),
      .spawn_x          (spawn_x),
      .spawn_y          (spawn_y),
      .tl_bound         (tl_bound),
      .tr_bound         (tr_bound),
      .bl_bound         (bl_bound),
      .br_bound         (br_bound),
      .PlayerX          (PlayerX),
      .PlayerY          (PlayerY),
      .PlayerS          (PlayerS),
      .tl_index         (tl_index),
      .tr_index         (tr_index),
      .bl_index         (bl_index),
      .br_index         (br_index),
      .player_visible   (player_visible),
      .state_o          (state_o),
      .death_bcd        (death_bcd)
   );

   always #5 frame_clk = ~frame_clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge frame_clk);
      #1;
   endtask

   task automatic load_level(input int sx, input int sy);
      spawn_x   = 10'(sx);
      spawn_y   = 10'(sy);
      new_level = 1'b1;
      tick();
      new_level = 1'b0;
   endtask

   task automatic test_reset();
      Reset = 1'b1; dead = 1'b0; initialize_level = 1'b0; new_level = 1'b0;
      keycode = '0; spawn_x = 10'd320; spawn_y = 10'd240;
      tl_bound = '0; tr_bound = '0; bl_bound = '0; br_bound = '0;
      tick();
      tick();
      Reset = 1'b0;
      n_checks++; if (PlayerX !== 10'd320) begin n_fail++; $display("FAIL reset_x got %0d want 320", PlayerX); end
      n_checks++; if (PlayerY !== 10'd240) begin n_fail++; $display("FAIL reset_y got %0d want 240", PlayerY); end
      n_checks++; if (death_bcd !== 12'h000) begin n_fail++; $display("FAIL reset_bcd got %h want 000", death_bcd); end
      n_checks++; if (tl_index !== 12'd149) begin n_fail++; $display("FAIL reset_tl_index got %0d want 149", tl_index); end
      n_checks++; if (tr_index !== 12'd150) begin n_fail++; $display("FAIL reset_tr_index got %0d want 150", tr_index); end
      n_checks++; if (player_visible !== 1'b1) begin n_fail++; $display("FAIL reset_visible got %b want 1", player_visible); end
      n_checks++; if (state_o !== 2'd0) begin n_fail++; $display("FAIL reset_state got %0d want 0", state_o); end
      n_checks++; if (PlayerS !== 10'd20) begin n_fail++; $display("FAIL reset_size got %0d want 20", PlayerS); end
   endtask

   // Two keys placed in arbitrary slots; expected position advances by dx,dy each frame
   task automatic test_move(input int slot1, input logic [7:0] k1,
                            input int slot2, input logic [7:0] k2,
                            input int dx, input int dy);
      exp_t e;
      logic [31:0] kc;
      load_level(320, 240);
      kc = '0;
      kc[8*slot1 +: 8] = k1;
      kc[8*slot2 +: 8] = k2;
      keycode = kc;
      for (int i = 1; i <= 5; i++) begin
         e.x = 320 + dx * i; e.y = 240 + dy * i; e.st = 0; e.vis = 1; e.bcd = 0;
         sb.push_back(e);
         tick();
         e = sb.pop_front();
         n_checks++; if (int'(PlayerX) != e.x || int'(PlayerY) != e.y) begin
            n_fail++; $display("FAIL move_s%0d_s%0d f%0d got (%0d,%0d) want (%0d,%0d)",
                               slot1, slot2, i, PlayerX, PlayerY, e.x, e.y);
         end
      end
      keycode = '0;
   endtask

   task automatic test_wall();
      exp_t e;
      load_level(43, 240);
      tl_bound = 4'b0001; bl_bound = 4'b0001;
      keycode  = {8'h00, 8'h1A, 8'h00, 8'h04};
      for (int i = 1; i <= 4; i++) begin
         e.x = 43; e.y = 240 - 2 * i; e.st = 0; e.vis = 1; e.bcd = 0;
         sb.push_back(e);
         tick();
         e = sb.pop_front();
         n_checks++; if (int'(PlayerX) != e.x || int'(PlayerY) != e.y) begin
            n_fail++; $display("FAIL wall_left f%0d got (%0d,%0d) want (%0d,%0d)",
                               i, PlayerX, PlayerY, e.x, e.y);
         end
      end
      tl_bound = '0; bl_bound = '0; keycode = '0;
   endtask

   // Screen edges: right clamp with D, A+D cancel, left clamp with A
   task automatic test_clamp();
      exp_t e;
      logic [31:0] kc [3];
      int          sx [3];
      kc[0] = {24'h0, 8'h07}; sx[0] = 629;
      kc[1] = {8'h04, 16'h0, 8'h07}; sx[1] = 629;
      kc[2] = {16'h0, 8'h04, 8'h00}; sx[2] = 10;
      for (int c = 0; c < 3; c++) begin
         load_level(sx[c], 240);
         keycode = kc[c];
         for (int i = 1; i <= 3; i++) begin
            e.x = sx[c]; e.y = 240; e.st = 0; e.vis = 1; e.bcd = 0;
            sb.push_back(e);
            tick();
            e = sb.pop_front();
            n_checks++; if (int'(PlayerX) != e.x || int'(PlayerY) != e.y) begin
               n_fail++; $display("FAIL clamp_c%0d f%0d got (%0d,%0d) want (%0d,%0d)",
                                  c, i, PlayerX, PlayerY, e.x, e.y);
            end
         end
      end
      keycode = '0;
   endtask

   task automatic test_death();
      exp_t e;
      int   budget;
      load_level(320, 240);
      keycode = {24'h0, 8'h04};
      repeat (3) tick();
      n_checks++; if (PlayerX !== 10'd314) begin n_fail++; $display("FAIL death_premove got %0d want 314", PlayerX); end
      dead = 1'b1;
      for (int i = 1; i <= 31; i++) begin
         if (i == 4) dead = 1'b0;
         e.x = 320; e.y = 240; e.bcd = 1;
         e.st  = (i <= 30) ? 1 : 0;
         e.vis = (i <= 30) ? 0 : 1;
         sb.push_back(e);
         tick();
         e = sb.pop_front();
         n_checks++; if (int'(state_o) != e.st || int'(player_visible) != e.vis ||
                         int'(PlayerX) != e.x || int'(PlayerY) != e.y || int'(death_bcd) != e.bcd) begin
            n_fail++; $display("FAIL death_f%0d got st=%0d vis=%0d pos=(%0d,%0d) bcd=%h want st=%0d vis=%0d pos=(%0d,%0d) bcd=%h",
                               i, state_o, player_visible, PlayerX, PlayerY, death_bcd,
                               e.st, e.vis, e.x, e.y, e.bcd);
         end
      end
      keycode = '0;
      dead = 1'b1;
      tick();
      dead = 1'b0;
      n_checks++; if (death_bcd !== 12'h002) begin n_fail++; $display("FAIL death_second got %h want 002", death_bcd); end
      budget = 0;
      while (state_o !== 2'd0 && budget < 40) begin tick(); budget++; end
      n_checks++; if (state_o !== 2'd0) begin n_fail++; $display("FAIL death_return timeout state=%0d want 0", state_o); end
   endtask

   task automatic test_saturate();
      for (int i = 0; i < 997; i++) begin
         dead = 1'b1;
         tick();
         dead = 1'b0;
         repeat (30) tick();
      end
      n_checks++; if (death_bcd !== 12'h999) begin n_fail++; $display("FAIL sat_reach got %h want 999", death_bcd); end
      n_checks++; if (state_o !== 2'd0) begin n_fail++; $display("FAIL sat_state got %0d want 0", state_o); end
      dead = 1'b1;
      tick();
      dead = 1'b0;
      n_checks++; if (death_bcd !== 12'h999) begin n_fail++; $display("FAIL sat_hold got %h want 999", death_bcd); end
      n_checks++; if (state_o !== 2'd1) begin n_fail++; $display("FAIL sat_dying got %0d want 1", state_o); end
      repeat (5) tick();
      spawn_x = 10'd200; spawn_y = 10'd100;
      new_level = 1'b1;
      tick();
      new_level = 1'b0;
      n_checks++; if (death_bcd !== 12'h000) begin n_fail++; $display("FAIL lvl_clear got %h want 000", death_bcd); end
      n_checks++; if (state_o !== 2'd0) begin n_fail++; $display("FAIL lvl_state got %0d want 0", state_o); end
      n_checks++; if (player_visible !== 1'b1) begin n_fail++; $display("FAIL lvl_visible got %b want 1", player_visible); end
      n_checks++; if (PlayerX !== 10'd200 || PlayerY !== 10'd100) begin
         n_fail++; $display("FAIL lvl_pos got (%0d,%0d) want (200,100)", PlayerX, PlayerY);
      end
   endtask

   initial begin
      test_reset();
      test_move(1, KEY_A, 3, KEY_W, -2, -2);
      test_move(3, KEY_A, 1, KEY_W, -2, -2);
      test_move(0, KEY_S, 2, KEY_D,  2,  2);
      test_wall();
      test_clamp();
      test_death();
      test_saturate();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
